// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter that shares the single sdram_ctrl slave port among NUM_M masters.
// A grant is held for a whole WB cycle, and a slave that never acks is aborted after TIMEOUT cycles.
`timescale 1ns/1ps
module wb_sdram_arbiter #(
    parameter int NUM_M   = 2,
    parameter int AW      = 23,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_dat_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_M-1:0]    m_stall_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    output logic [NUM_M-1:0]    grant_o,
    output logic                busy_o
);
    localparam int IW = $clog2(NUM_M);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]   NM   = (IW+1)'(NUM_M);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic [NUM_M-1:0]         req;
    logic [2*NUM_M-1:0]       req_rot;
    logic [IW:0]              sum;
    logic [IW:0]              nsum;
    logic [IW-1:0]            pick;
    logic                     pick_vld;
    logic [IW-1:0]            gnext;
    logic                     own;
    logic [NUM_M-1:0][AW-1:0] addr_v;
    logic [NUM_M-1:0][DW-1:0] wdat_v;

    assign req    = m_cyc_i & m_stb_i;
    assign addr_v = m_addr_i;
    assign wdat_v = m_dat_i;

    // Rotate requests so bit 0 is the pointer's master; the lowest set bit wins.
    always_comb begin
        req_rot  = {req, req} >> ptr_q;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, ptr_q} + (IW+1)'(k);
                if (sum >= NM) sum = sum - NM;
                pick     = sum[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        nsum = {1'b0, gidx_q} + (IW+1)'(1);
        if (nsum >= NM) nsum = '0;
        gnext = nsum[IW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        tcnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d       = OWN;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gidx_d        = pick;
                end
            end
            OWN: begin
                // Releasing cyc beats everything; an ack on the limit cycle beats the abort.
                if (!m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gnext;
                end else if (s_ack_i || !m_stb_i[gidx_q]) begin
                    tcnt_d = '0;
                end else if (tcnt_q == TMAX) begin
                    state_d = ABORT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = gnext;
            end
            default: state_d = IDLE;
        endcase
    end

    assign own       = (state_q == OWN);
    assign s_cyc_o   = own & m_cyc_i[gidx_q];
    assign s_stb_o   = own & m_stb_i[gidx_q];
    assign s_we_o    = m_we_i[gidx_q];
    assign s_addr_o  = addr_v[gidx_q];
    assign s_dat_o   = wdat_v[gidx_q];
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = (own && s_ack_i) ? grant_q : '0;
    assign m_err_o   = (state_q == ABORT) ? grant_q : '0;
    assign m_stall_o = ~grant_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
endmodule
